tap_pattern_gen: RTL and testbench

- Binary-to-tap-pattern decoder and sequencer for the 195-tap delay-line TDC; the inverse of the one-hot-to-binary encoder.
- Takes a binary tap index, or sweeps all indices, and drives a registered one-hot or thermometer word onto a 195-bit tap bus for a programmable hold time.
- Used for encoder loopback self-test and for calibration of the tap-code path ahead of the encoder.

---
 rtl/tdc_pkg.sv | 15 +
 rtl/tap_decode.sv | 19 +
 rtl/tap_pattern_gen.sv | 169 ++++++++++++++++
 tb/tb_tap_pattern_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared constants and FSM state encoding for the TDC tap-pattern path.
package tdc_pkg;

  localparam int N_TAPS = 195;
  localparam int IDX_W  = 8;
  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/tap_decode.sv
// Combinational binary-index to tap-pattern decoder (one-hot or thermometer).
// Each bit is a plain compare of its own constant position against idx, so the
// block can be reused as the reference side of an encoder-loopback checker.
module tap_decode #(
  parameter int N_TAPS = tdc_pkg::N_TAPS,
  parameter int IDX_W  = tdc_pkg::IDX_W
) (
  input  logic [IDX_W-1:0]  idx,
  input  logic              thermo,
  output logic [N_TAPS-1:0] pattern
);

  // Per-bit compare: equality for one-hot, less-or-equal for thermometer (LSB0).
  for (genvar i = 0; i < N_TAPS; i++) begin : g_bit
    localparam logic [IDX_W-1:0] LP_POS = IDX_W'(i);
    assign pattern[i] = thermo ? (LP_POS <= idx) : (LP_POS == idx);
  end

endmodule

// File: rtl/tap_pattern_gen.sv
// Tap-pattern sequencer: drives a registered one-hot/thermometer word onto the
// tap bus for a single index or a sweep of all indices, with programmable hold.
module tap_pattern_gen #(
  parameter int N_TAPS = tdc_pkg::N_TAPS,
  parameter int IDX_W  = tdc_pkg::IDX_W,
  parameter int HOLD_W = tdc_pkg::HOLD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              thermo_sel,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic [IDX_W-1:0]  idx_in,
  input  logic              idx_valid,
  output logic              idx_ready,
  output logic [N_TAPS-1:0] pattern_out,
  output logic              pattern_valid,
  output logic [IDX_W-1:0]  cur_index,
  output logic              busy,
  output logic              done,
  output logic              err_range
);

  import tdc_pkg::*;

  localparam logic [IDX_W-1:0] LP_MAX_IDX = IDX_W'(N_TAPS - 1);

  state_t              r_state;
  logic                r_run;
  logic                r_sweep;
  logic                r_thermo;
  logic [HOLD_W-1:0]   r_hold;
  logic [HOLD_W-1:0]   r_cnt;
  logic [IDX_W-1:0]    r_cur_index;
  logic [N_TAPS-1:0]   r_pattern;
  logic                r_pattern_valid;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  state_t              w_nxt_state;
  logic                w_nxt_sweep;
  logic                w_nxt_thermo;
  logic [HOLD_W-1:0]   w_nxt_hold;
  logic [HOLD_W-1:0]   w_nxt_cnt;
  logic [IDX_W-1:0]    w_nxt_index;
  logic                w_nxt_pv;
  logic                w_nxt_err;
  logic [N_TAPS-1:0]   w_dec_pattern;

  // r_run keeps idx_ready low while reset is held and until the first clock after release.
  assign idx_ready = r_run & (r_state == IDLE) & ~start & ~abort;

  // The decoder sees the index/mode of the coming cycle so its output can be registered.
  tap_decode #(
    .N_TAPS (N_TAPS),
    .IDX_W  (IDX_W)
  ) u_tap_decode (
    .idx     (w_nxt_index),
    .thermo  (w_nxt_thermo),
    .pattern (w_dec_pattern)
  );

  // Next-state, next-index and hold-counter logic; abort overrides any active state.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_sweep  = r_sweep;
    w_nxt_thermo = r_thermo;
    w_nxt_hold   = r_hold;
    w_nxt_cnt    = r_cnt;
    w_nxt_index  = r_cur_index;
    w_nxt_pv     = 1'b0;
    w_nxt_err    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nxt_state  = DRIVE;
          w_nxt_sweep  = 1'b1;
          w_nxt_index  = '0;
          w_nxt_thermo = thermo_sel;
          w_nxt_hold   = hold_cycles;
          w_nxt_cnt    = hold_cycles;
          w_nxt_pv     = 1'b1;
        end else if (idx_valid && idx_ready) begin
          if (idx_in > LP_MAX_IDX) begin
            w_nxt_err = 1'b1;
          end else begin
            w_nxt_state  = DRIVE;
            w_nxt_sweep  = 1'b0;
            w_nxt_index  = idx_in;
            w_nxt_thermo = thermo_sel;
            w_nxt_hold   = hold_cycles;
            w_nxt_cnt    = hold_cycles;
            w_nxt_pv     = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (r_cnt == '0) begin
          w_nxt_state = GAP;
        end else begin
          w_nxt_cnt = r_cnt - HOLD_W'(1);
          w_nxt_pv  = 1'b1;
        end
      end
      GAP: begin
        if (r_sweep && (r_cur_index != LP_MAX_IDX)) begin
          w_nxt_state = DRIVE;
          w_nxt_index = r_cur_index + IDX_W'(1);
          w_nxt_cnt   = r_hold;
          w_nxt_pv    = 1'b1;
        end else begin
          w_nxt_state = FIN;
        end
      end
      FIN: begin
        w_nxt_state = IDLE;
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase
    if (abort && (r_state != IDLE)) begin
      w_nxt_state = IDLE;
      w_nxt_index = r_cur_index;
      w_nxt_pv    = 1'b0;
    end
  end

  // State and registered outputs; everything clears asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_run           <= 1'b0;
      r_sweep         <= 1'b0;
      r_thermo        <= 1'b0;
      r_hold          <= '0;
      r_cnt           <= '0;
      r_cur_index     <= '0;
      r_pattern       <= '0;
      r_pattern_valid <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_state         <= w_nxt_state;
      r_run           <= 1'b1;
      r_sweep         <= w_nxt_sweep;
      r_thermo        <= w_nxt_thermo;
      r_hold          <= w_nxt_hold;
      r_cnt           <= w_nxt_cnt;
      r_cur_index     <= w_nxt_index;
      r_pattern       <= w_nxt_pv ? w_dec_pattern : '0;
      r_pattern_valid <= w_nxt_pv;
      r_busy          <= (w_nxt_state != IDLE);
      r_done          <= (w_nxt_state == FIN);
      r_err           <= w_nxt_err;
    end
  end

  assign pattern_out   = r_pattern;
  assign pattern_valid = r_pattern_valid;
  assign cur_index     = r_cur_index;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err_range     = r_err;

endmodule

// File: tb/tb_tap_pattern_gen.sv
// Self-checking bench for tap_pattern_gen: vector table of single shots,
// plus sweep, simultaneous start/idx, held-value, abort and reset sequences.
module tb_tap_pattern_gen;

  localparam int NT = 195;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           abort;
  logic           thermo_sel;
  logic [7:0]     hold_cycles;
  logic [7:0]     idx_in;
  logic           idx_valid;
  logic           idx_ready;
  logic [NT-1:0]  pattern_out;
  logic           pattern_valid;
  logic [7:0]     cur_index;
  logic           busy;
  logic           done;
  logic           err_range;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [NT-1:0] pat;
    logic [7:0]    idx;
    logic          th;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] idx;
    logic       th;
    logic [7:0] hold;
    logic       err;
  } vec_t;
  vec_t vt[8];

  tap_pattern_gen dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .thermo_sel    (thermo_sel),
    .hold_cycles   (hold_cycles),
    .idx_in        (idx_in),
    .idx_valid     (idx_valid),
    .idx_ready     (idx_ready),
    .pattern_out   (pattern_out),
    .pattern_valid (pattern_valid),
    .cur_index     (cur_index),
    .busy          (busy),
    .done          (done),
    .err_range     (err_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference pattern built arithmetically rather than per-bit.
  function automatic logic [NT-1:0] pat_model(input int idx, input logic th);
    logic [NT-1:0] one;
    one = NT'(1) << idx;
    return th ? ((one << 1) - NT'(1)) : one;
  endfunction

  function automatic int enc(input logic [NT-1:0] p);
    int r;
    r = -1;
    for (int i = 0; i < NT; i++) if (p[i]) r = i;
    return r;
  endfunction

  task automatic push_exp(input int idx, input logic th, input int hold);
    exp_t e;
    e.pat = pat_model(idx, th);
    e.idx = 8'(idx);
    e.th  = th;
    for (int k = 0; k <= hold; k++) sb.push_back(e);
  endtask

  // Scoreboard consumer: every valid pattern cycle pops one expected entry.
  always @(negedge clk) begin
    if (rst_n && pattern_valid) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 256'(1), 256'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pattern", 256'(pattern_out), 256'(e.pat));
        check("cur_index", 256'(cur_index), 256'(e.idx));
        if (!e.th) check("loopback", 256'(enc(pattern_out)), 256'(cur_index));
      end
    end
  end

  task automatic do_single(input logic [7:0] idx, input logic th, input logic [7:0] hold,
                           input logic exp_err);
    @(negedge clk);
    check("ready_pre", 256'(idx_ready), 256'(1));
    idx_in = idx; idx_valid = 1'b1; thermo_sel = th; hold_cycles = hold;
    if (!exp_err) push_exp(int'(idx), th, int'(hold));
    @(negedge clk);
    idx_valid = 1'b0; thermo_sel = ~th; hold_cycles = hold + 8'd3;
    if (exp_err) begin
      check("err_pulse", 256'(err_range), 256'(1));
      check("err_busy", 256'(busy), 256'(0));
      check("err_pv", 256'(pattern_valid), 256'(0));
      @(negedge clk);
      check("err_clear", 256'(err_range), 256'(0));
      check("err_pv2", 256'(pattern_valid), 256'(0));
      check("err_busy2", 256'(busy), 256'(0));
    end else begin
      check("drv_busy", 256'(busy), 256'(1));
      check("drv_pv", 256'(pattern_valid), 256'(1));
      for (int k = 0; k < int'(hold); k++) begin
        @(negedge clk);
        check("drv_hold_pv", 256'(pattern_valid), 256'(1));
      end
      @(negedge clk);
      check("gap_pv", 256'(pattern_valid), 256'(0));
      check("gap_pat", 256'(pattern_out), 256'(0));
      check("gap_done", 256'(done), 256'(0));
      @(negedge clk);
      check("fin_done", 256'(done), 256'(1));
      check("fin_busy", 256'(busy), 256'(1));
      @(negedge clk);
      check("idle_done", 256'(done), 256'(0));
      check("idle_busy", 256'(busy), 256'(0));
      check("idle_ready", 256'(idx_ready), 256'(1));
    end
    check("sb_drained", 256'(sb.size()), 256'(0));
  endtask

  initial begin
    int n;
    int done_seen;

    vt[0] = '{idx: 8'd37,  th: 1'b0, hold: 8'd2, err: 1'b0};
    vt[1] = '{idx: 8'd194, th: 1'b1, hold: 8'd0, err: 1'b0};
    vt[2] = '{idx: 8'd0,   th: 1'b1, hold: 8'd0, err: 1'b0};
    vt[3] = '{idx: 8'd195, th: 1'b0, hold: 8'd0, err: 1'b1};
    vt[4] = '{idx: 8'd255, th: 1'b1, hold: 8'd3, err: 1'b1};
    vt[5] = '{idx: 8'd100, th: 1'b0, hold: 8'd1, err: 1'b0};
    vt[6] = '{idx: 8'd5,   th: 1'b1, hold: 8'd4, err: 1'b0};
    vt[7] = '{idx: 8'd194, th: 1'b0, hold: 8'd0, err: 1'b0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; thermo_sel = 1'b0;
    hold_cycles = 8'd0; idx_in = 8'd0; idx_valid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pat", 256'(pattern_out), 256'(0));
    check("rst_pv", 256'(pattern_valid), 256'(0));
    check("rst_idx", 256'(cur_index), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_err", 256'(err_range), 256'(0));
    check("rst_ready", 256'(idx_ready), 256'(0));
    rst_n = 1'b1;
    #1;
    check("rel_ready_pre_clk", 256'(idx_ready), 256'(0));
    @(negedge clk);
    check("rel_ready", 256'(idx_ready), 256'(1));

    // Table of single-shot and range-error vectors
    for (int v = 0; v < 8; v++) do_single(vt[v].idx, vt[v].th, vt[v].hold, vt[v].err);

    // Sweep started together with idx_valid; hold/thermo changed mid-sweep
    @(negedge clk);
    start = 1'b1; idx_valid = 1'b1; idx_in = 8'd5; hold_cycles = 8'd0; thermo_sel = 1'b0;
    #1;
    check("start_blocks_ready", 256'(idx_ready), 256'(0));
    for (int i = 0; i < NT; i++) push_exp(i, 1'b0, 0);
    @(negedge clk);
    start = 1'b0; idx_valid = 1'b0;
    n = 1;
    while (!done && n < 1000) begin
      if (n == 20) begin hold_cycles = 8'd7; thermo_sel = 1'b1; end
      @(negedge clk);
      n++;
    end
    check("sweep_len", 256'(n), 256'(391));
    check("sweep_last_idx", 256'(cur_index), 256'(194));
    check("sweep_sb_drained", 256'(sb.size()), 256'(0));
    @(negedge clk);
    check("sweep_idle", 256'(busy), 256'(0));

    // Abort at index 50 of a sweep
    thermo_sel = 1'b0; hold_cycles = 8'd1;
    start = 1'b1;
    for (int i = 0; i < NT; i++) push_exp(i, 1'b0, 1);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(pattern_valid && cur_index == 8'd50) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_50", 256'(n < 1000), 256'(1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_pv", 256'(pattern_valid), 256'(0));
    check("abort_pat", 256'(pattern_out), 256'(0));
    check("abort_busy", 256'(busy), 256'(0));
    check("abort_ready", 256'(idx_ready), 256'(1));
    done_seen = 0;
    repeat (6) begin
      if (done || pattern_valid) done_seen = 1;
      @(negedge clk);
    end
    check("abort_no_done", 256'(done_seen), 256'(0));
    sb.delete();

    // Reset asserted mid-DRIVE, then normal resumption
    @(negedge clk);
    idx_in = 8'd60; idx_valid = 1'b1; thermo_sel = 1'b1; hold_cycles = 8'd10;
    push_exp(60, 1'b1, 10);
    @(negedge clk);
    idx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_pv", 256'(pattern_valid), 256'(1));
    rst_n = 1'b0;
    #1;
    check("mrst_pat", 256'(pattern_out), 256'(0));
    check("mrst_pv", 256'(pattern_valid), 256'(0));
    check("mrst_busy", 256'(busy), 256'(0));
    check("mrst_idx", 256'(cur_index), 256'(0));
    check("mrst_done", 256'(done), 256'(0));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_no_done", 256'(done), 256'(0));
    do_single(8'd12, 1'b0, 8'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
